// File: rtl/vga_pkg.sv
// Shared timing constants and colour helpers for the VGA raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate from a 50 MHz clock.
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // RGB332 field positions inside the 8-bit pixel word
    localparam int unsigned RGB_R_MSB = 7;
    localparam int unsigned RGB_R_LSB = 5;
    localparam int unsigned RGB_G_MSB = 4;
    localparam int unsigned RGB_G_LSB = 2;
    localparam int unsigned RGB_B_MSB = 1;
    localparam int unsigned RGB_B_LSB = 0;

    localparam int unsigned RGB_CH_W = 8;

    // Total period of one axis: active + front porch + sync + back porch
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    // Bit replication keeps full-scale at 8'hFF and zero at zero
    function automatic logic [RGB_CH_W-1:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [RGB_CH_W-1:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request / DAC bundle of the VGA timing generator.
// master = timing generator, slave = frame-buffer renderer plus DAC.
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic [7:0]    rgb_8;
    logic          pixel_en;
    logic          pix_tick;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    r_out;
    logic [7:0]    g_out;
    logic [7:0]    b_out;
    logic          de_out;
    logic          h_sync;
    logic          v_sync;

    modport master (
        input  rgb_8,
        output pixel_en, pix_tick, x, y, line_start, frame_start,
        output r_out, g_out, b_out, de_out, h_sync, v_sync
    );

    modport slave (
        output rgb_8,
        input  pixel_en, pix_tick, x, y, line_start, frame_start,
        input  r_out, g_out, b_out, de_out, h_sync, v_sync
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active and sync decode.
// Region order along the axis is active, front porch, sync, back porch.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync_raw,
    output logic         wrap
);

    localparam int unsigned TOT      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_BEG = ACTIVE + FP;
    localparam int unsigned SYNC_END = ACTIVE + FP + SYNC;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Terminal count: the next advance returns to zero
    assign wrap = (cnt_q == W'(TOT - 1));

    // Next position: hold unless advanced, wrap at the end of the period
    always_comb begin
        cnt_d = cnt_q;
        if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    // Position register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign active   = (cnt_q < W'(ACTIVE));
    assign sync_raw = (cnt_q >= W'(SYNC_BEG)) && (cnt_q < W'(SYNC_END));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD raster timing generator with RGB332 -> RGB888 output.
// Stage 0 presents x/y/pixel_en from the counters; stage 1 registers colour,
// DE and sync on the pixel tick so all DAC signals trail x/y by one pixel.
// Optional macro VGA_TEST_PATTERN_EN adds input test_mode, which replaces
// rgb_8 with eight vertical colour bars inside a one-pixel white border.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV         = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned H_FP            = DEF_H_FP,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BP            = DEF_H_BP,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned V_FP            = DEF_V_FP,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BP            = DEF_V_BP,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned XW              = 10,
    parameter int unsigned YW              = 10
) (
    input  logic clk,
    input  logic rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic test_mode,
`endif
    vga_timing_gen_if.master bus
);

    localparam int unsigned DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // ---------------- pixel clock divider ----------------
    logic [DIVW-1:0] div_q;
    logic [DIVW-1:0] div_d;
    logic            div_last;
    logic            tick;

    assign div_last = (div_q == DIVW'(CLK_DIV - 1));
    // Tick is suppressed during reset so no strobe escapes a reset cycle
    assign tick     = div_last && !rst;

    // Divider next value: count 0..CLK_DIV-1
    always_comb begin
        div_d = div_last ? '0 : div_q + DIVW'(1);
    end

    // Divider register
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ---------------- raster counters ----------------
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_active;
    logic          v_active;
    logic          h_sync_raw;
    logic          v_sync_raw;
    logic          h_wrap;
    // End-of-frame flag is not needed: frame_start keys off the counter origin
    logic          unused_v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (XW)
    ) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .adv      (tick),
        .cnt      (h_cnt),
        .active   (h_active),
        .sync_raw (h_sync_raw),
        .wrap     (h_wrap)
    );

    // Lines advance on the tick that wraps the horizontal counter
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (YW)
    ) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .adv      (tick && h_wrap),
        .cnt      (v_cnt),
        .active   (v_active),
        .sync_raw (v_sync_raw),
        .wrap     (unused_v_wrap)
    );

    // ---------------- stage 0: request side ----------------
    logic pixel_en;
    logic line_start;

    assign pixel_en   = h_active && v_active;
    assign line_start = tick && (h_cnt == '0);

    assign bus.pix_tick    = tick;
    assign bus.x           = h_cnt;
    assign bus.y           = v_cnt;
    assign bus.pixel_en    = pixel_en;
    assign bus.line_start  = line_start;
    assign bus.frame_start = line_start && (v_cnt == '0);

    // ---------------- colour source ----------------
    logic [7:0] src_r;
    logic [7:0] src_g;
    logic [7:0] src_b;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    logic       border;

    assign bar    = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
    assign border = (h_cnt == '0) || (h_cnt == XW'(H_ACTIVE - 1)) ||
                    (v_cnt == '0) || (v_cnt == YW'(V_ACTIVE - 1));
`endif

    // RGB332 expansion, or the bar pattern when test mode is selected
    always_comb begin
        src_r = expand3(bus.rgb_8[RGB_R_MSB:RGB_R_LSB]);
        src_g = expand3(bus.rgb_8[RGB_G_MSB:RGB_G_LSB]);
        src_b = expand2(bus.rgb_8[RGB_B_MSB:RGB_B_LSB]);
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            src_r = {8{border || bar[2]}};
            src_g = {8{border || bar[1]}};
            src_b = {8{border || bar[0]}};
        end
`endif
    end

    // ---------------- stage 1: DAC side ----------------
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       de_q, de_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    // Capture colour/DE/sync for the requested pixel on each tick, hold otherwise
    always_comb begin
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (tick) begin
            de_d = pixel_en;
            hs_d = h_sync_raw ^ SYNC_ACTIVE_LOW;
            vs_d = v_sync_raw ^ SYNC_ACTIVE_LOW;
            r_d  = pixel_en ? src_r : 8'h00;
            g_d  = pixel_en ? src_g : 8'h00;
            b_d  = pixel_en ? src_b : 8'h00;
        end
    end

    // Output registers; syncs idle at their inactive level in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= 8'h00;
            g_q  <= 8'h00;
            b_q  <= 8'h00;
            de_q <= 1'b0;
            hs_q <= SYNC_ACTIVE_LOW;
            vs_q <= SYNC_ACTIVE_LOW;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign bus.r_out  = r_q;
    assign bus.g_out  = g_q;
    assign bus.b_out  = b_q;
    assign bus.de_out = de_q;
    assign bus.h_sync = hs_q;
    assign bus.v_sync = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster at /2, small raster
// at /1 with active-high sync, default 640x480) checked every cycle against
// a time-based raster model, plus hand-computed timing and colour literals.
module tb_vga_timing_gen;

    typedef struct {
        int d;
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        bit sal;
    } cfg_t;

    typedef struct {
        logic [31:0] tick, ls, fs, pen, x, y, de, hs, vs, r, g, b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t   = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   chk_en  = 1'b0;
    bit   meas_en = 1'b0;
    cfg_t cfg [3];

    int ls0 [3];
    int ls1 [3];
    int hs_on [3];
    int hs_off [3];
    int vs_on  = -1;
    int vs_cnt = 0;
    int de_cnt = 0;

    always #5 clk = ~clk;

    // Clocks since the last reset edge; the model is a pure function of it
    always @(posedge clk) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    vga_timing_gen_if #(.XW(5), .YW(4)) bus_a ();
    vga_timing_gen_if #(.XW(5), .YW(4)) bus_b ();
    vga_timing_gen_if                   bus_c ();

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE_LOW(1'b1), .XW(5), .YW(4)
    ) dut_a (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .bus(bus_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE_LOW(1'b0), .XW(5), .YW(4)
    ) dut_b (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .bus(bus_b)
    );

    vga_timing_gen dut_c (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .bus(bus_c)
    );

    // Pixel colour the renderer supplies for position (h,v)
    function automatic logic [7:0] stim(input int h, input int v);
        case (v % 4)
            0:       return 8'(h);
            1:       return 8'hFF;
            2:       return 8'h92;
            default: return 8'(h * 37 + v * 11 + 5);
        endcase
    endfunction

    function automatic bit in_win(input int pos, input int lo, input int w);
        return (pos >= lo) && (pos < lo + w);
    endfunction

    // Expected outputs t clocks after reset release (t=0 also during reset)
    function automatic exp_t model(input cfg_t c, input int tt, input bit in_rst);
        exp_t e;
        int ht, vt, p, q, h, v, hq, vq;
        logic [7:0] s;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        p  = tt / c.d;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.tick = 32'(!in_rst && (tt % c.d == c.d - 1));
        e.x    = 32'(h);
        e.y    = 32'(v);
        e.pen  = 32'(h < c.ha && v < c.va);
        e.ls   = 32'(e.tick == 1 && h == 0);
        e.fs   = 32'(e.tick == 1 && h == 0 && v == 0);
        e.de   = 0;
        e.r    = 0;
        e.g    = 0;
        e.b    = 0;
        e.hs   = 32'(c.sal);
        e.vs   = 32'(c.sal);
        if (p > 0) begin
            q  = p - 1;
            hq = q % ht;
            vq = (q / ht) % vt;
            e.hs = 32'(in_win(hq, c.ha + c.hfp, c.hs) ^ c.sal);
            e.vs = 32'(in_win(vq, c.va + c.vfp, c.vs) ^ c.sal);
            if (hq < c.ha && vq < c.va) begin
                s    = stim(hq, vq);
                e.de = 1;
                e.r  = 32'((int'(s[7:5]) * 255 + 3) / 7);
                e.g  = 32'((int'(s[4:2]) * 255 + 3) / 7);
                e.b  = 32'(int'(s[1:0]) * 85);
            end
        end
        return e;
    endfunction

    function automatic exp_t grab(input int d);
        exp_t a;
        case (d)
            0: a = '{32'(bus_a.pix_tick), 32'(bus_a.line_start), 32'(bus_a.frame_start), 32'(bus_a.pixel_en), 32'(bus_a.x), 32'(bus_a.y), 32'(bus_a.de_out), 32'(bus_a.h_sync), 32'(bus_a.v_sync), 32'(bus_a.r_out), 32'(bus_a.g_out), 32'(bus_a.b_out)};
            1: a = '{32'(bus_b.pix_tick), 32'(bus_b.line_start), 32'(bus_b.frame_start), 32'(bus_b.pixel_en), 32'(bus_b.x), 32'(bus_b.y), 32'(bus_b.de_out), 32'(bus_b.h_sync), 32'(bus_b.v_sync), 32'(bus_b.r_out), 32'(bus_b.g_out), 32'(bus_b.b_out)};
            default: a = '{32'(bus_c.pix_tick), 32'(bus_c.line_start), 32'(bus_c.frame_start), 32'(bus_c.pixel_en), 32'(bus_c.x), 32'(bus_c.y), 32'(bus_c.de_out), 32'(bus_c.h_sync), 32'(bus_c.v_sync), 32'(bus_c.r_out), 32'(bus_c.g_out), 32'(bus_c.b_out)};
        endcase
        return a;
    endfunction

    function automatic logic [7:0] stim_at(input cfg_t c, input int tt);
        int ht, vt, p;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        p  = tt / c.d;
        return stim(p % ht, (p / ht) % vt);
    endfunction

    task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0d got=%0h expected=%0h", name, d, t, act, exp);
    endtask

    // Every-cycle comparison of all three instances against the model
    task automatic check_all();
        exp_t e, a;
        for (int d = 0; d < 3; d++) begin
            e = model(cfg[d], t, rst);
            a = grab(d);
            cmp("pix_tick", d, a.tick, e.tick);
            cmp("line_start", d, a.ls, e.ls);
            cmp("frame_start", d, a.fs, e.fs);
            cmp("pixel_en", d, a.pen, e.pen);
            cmp("x", d, a.x, e.x);
            cmp("y", d, a.y, e.y);
            cmp("de_out", d, a.de, e.de);
            cmp("h_sync", d, a.hs, e.hs);
            cmp("v_sync", d, a.vs, e.vs);
            cmp("r_out", d, a.r, e.r);
            cmp("g_out", d, a.g, e.g);
            cmp("b_out", d, a.b, e.b);
        end
    endtask

    // Line/sync timing capture and colour literals during the first run
    task automatic measure();
        exp_t a;
        bit   act;
        for (int d = 0; d < 3; d++) begin
            a = grab(d);
            if (a.ls == 1) begin
                if (ls0[d] < 0)      ls0[d] = t;
                else if (ls1[d] < 0) ls1[d] = t;
            end
            act = (a.hs != 32'(cfg[d].sal));
            if (ls0[d] >= 0 && hs_on[d] < 0 && act)           hs_on[d]  = t;
            else if (hs_on[d] >= 0 && hs_off[d] < 0 && !act)  hs_off[d] = t;
        end
        a = grab(0);
        if (t < 480) begin
            if (a.vs == 0) vs_cnt++;
            if (vs_on < 0 && a.vs == 0) vs_on = t;
            if (a.tick == 1 && a.de == 1) de_cnt++;
        end
        // Pixel p shows on the DAC from t=(p+1)*2; stim rows: x, FF, 92
        case (t)
            4:  begin cmp("lit_x1_r", 0, a.r, 32'h00); cmp("lit_x1_g", 0, a.g, 32'h00);
                      cmp("lit_x1_b", 0, a.b, 32'h55); cmp("lit_x1_de", 0, a.de, 32'd1); end
            36: begin cmp("lit_blank_r", 0, a.r, 32'h00); cmp("lit_blank_b", 0, a.b, 32'h00);
                      cmp("lit_blank_de", 0, a.de, 32'd0); end
            50: begin cmp("lit_ff_r", 0, a.r, 32'hFF); cmp("lit_ff_g", 0, a.g, 32'hFF);
                      cmp("lit_ff_b", 0, a.b, 32'hFF); end
            98: begin cmp("lit_92_r", 0, a.r, 32'h92); cmp("lit_92_g", 0, a.g, 32'h92);
                      cmp("lit_92_b", 0, a.b, 32'hAA); cmp("lit_92_de", 0, a.de, 32'd1); end
            default: ;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) check_all();
        if (meas_en) measure();
        if (!rst && t == 1) begin
            cmp("first_tick_fs", 0, 32'(bus_a.frame_start), 32'd1);
            cmp("first_tick_x", 0, 32'(bus_a.x), 32'd0);
            cmp("first_tick_y", 0, 32'(bus_a.y), 32'd0);
        end
        bus_a.rgb_8 = stim_at(cfg[0], t);
        bus_b.rgb_8 = stim_at(cfg[1], t);
        bus_c.rgb_8 = stim_at(cfg[2], t);
    endtask

    initial begin
        int exp_gap [3];
        int exp_dly [3];
        int exp_wid [3];
        bit found;
        cfg[0] = '{2, 16, 2, 3, 3, 6, 1, 2, 1, 1'b1};
        cfg[1] = '{1, 16, 2, 3, 3, 6, 1, 2, 1, 1'b0};
        cfg[2] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
        // line_start sits on the last clock of pixel 0, so sync lags it by (HA+HFP)*D+1
        exp_gap = '{48, 24, 1600};
        exp_dly = '{37, 19, 1313};
        exp_wid = '{6, 3, 192};
        for (int d = 0; d < 3; d++) begin
            ls0[d] = -1; ls1[d] = -1; hs_on[d] = -1; hs_off[d] = -1;
        end
        bus_a.rgb_8 = 8'h00;
        bus_b.rgb_8 = 8'h00;
        bus_c.rgb_8 = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        meas_en = 1'b1;
        repeat (1800) step();
        meas_en = 1'b0;

        for (int d = 0; d < 3; d++) begin
            cmp("line_len", d, 32'(ls1[d] - ls0[d]), 32'(exp_gap[d]));
            cmp("hsync_delay", d, 32'(hs_on[d] - ls0[d]), 32'(exp_dly[d]));
            cmp("hsync_width", d, 32'(hs_off[d] - hs_on[d]), 32'(exp_wid[d]));
        end
        // Line 7 starts at pixel 168 -> DAC at t=338; two lines of 24 px at /2
        cmp("vsync_start", 0, 32'(vs_on), 32'd338);
        cmp("vsync_clks", 0, 32'(vs_cnt), 32'd96);
        cmp("de_ticks", 0, 32'(de_cnt), 32'd96);

        // Abort a frame mid-line at (10,3) of the small /2 raster
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            step();
            if (((t / 2) % 240) == 82) found = 1'b1;
        end
        cmp("seek_x", 0, 32'(bus_a.x), 32'd10);
        cmp("seek_y", 0, 32'(bus_a.y), 32'd3);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (700) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
